// File: rtl/seg_scan_ctrl_if.sv
// Display-word handshake between a word source and the scan controller.
// The source drives msg_in/msg_valid; the controller answers with msg_ready.
interface seg_scan_ctrl_if;
   logic [15:0] msg_in;
   logic        msg_valid;
   logic        msg_ready;

   modport master (output msg_in, output msg_valid, input msg_ready);
   modport slave  (input msg_in, input msg_valid, output msg_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan scheduler: blank gap then drive per digit (3 down to 0),
// words are taken via valid/ready and swapped in only at frame boundaries.
module seg_scan_ctrl #(
   parameter int DIGIT_TICKS = 16,
   parameter int BLANK_TICKS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   seg_scan_ctrl_if.slave        msg,
   output logic [3:0]            AN_EN,
   output logic [3:0]            digit_val,
   output logic                  frame_done,
   output logic                  busy
);

   localparam int MAXT = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
   localparam int TW   = $clog2(MAXT + 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
   localparam logic [TW-1:0] DRIVE_LAST = TW'(DIGIT_TICKS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t         state_q, state_d;
   logic [1:0]     dig_q, dig_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic [15:0]    active_q, active_d;
   logic [15:0]    shadow_q, shadow_d;
   logic           sfull_q, sfull_d;
   logic [3:0]     an_q, an_d;
   logic [3:0]     dval_q, dval_d;
   logic           fdone_q, fdone_d;
   logic           busy_q, busy_d;
   logic           rdy_q, rdy_d;
   logic           xfer;
   logic           frame_end;

   assign xfer = msg.msg_valid & rdy_q;

   always_comb begin
      state_d   = state_q;
      dig_d     = dig_q;
      tick_d    = tick_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      sfull_d   = sfull_q;
      frame_end = 1'b0;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = BLANK;
               dig_d   = 2'd3;
               tick_d  = '0;
            end
         end
         BLANK: begin
            if (tick_q == BLANK_LAST) begin
               state_d = DRIVE;
               tick_d  = '0;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         DRIVE: begin
            if (tick_q == DRIVE_LAST) begin
               tick_d = '0;
               if (dig_q != 2'd0) begin
                  state_d = BLANK;
                  dig_d   = dig_q - 2'd1;
               end else begin
                  frame_end = 1'b1;
                  if (en) begin
                     state_d = BLANK;
                     dig_d   = 2'd3;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A ready transfer implies an empty shadow, so commit and capture never collide.
      if (frame_end && sfull_q) begin
         active_d = shadow_q;
         sfull_d  = 1'b0;
      end
      if (xfer) begin
         if (state_q == IDLE) begin
            active_d = msg.msg_in;
         end else begin
            shadow_d = msg.msg_in;
            sfull_d  = 1'b1;
         end
      end
   end

   // Outputs are registered from next-state so they line up with the state they describe.
   always_comb begin
      an_d = 4'b1111;
      if (state_d == DRIVE) begin
         an_d[dig_d] = 1'b0;
      end
      dval_d  = (state_d == IDLE) ? 4'h0 : active_d[{dig_d, 2'b00} +: 4];
      fdone_d = (state_d == DRIVE) && (dig_d == 2'd0) && (tick_d == DRIVE_LAST);
      busy_d  = (state_d != IDLE);
      rdy_d   = ~sfull_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         dig_q    <= 2'd3;
         tick_q   <= '0;
         active_q <= '0;
         shadow_q <= '0;
         sfull_q  <= 1'b0;
         an_q     <= 4'b1111;
         dval_q   <= 4'h0;
         fdone_q  <= 1'b0;
         busy_q   <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         dig_q    <= dig_d;
         tick_q   <= tick_d;
         active_q <= active_d;
         shadow_q <= shadow_d;
         sfull_q  <= sfull_d;
         an_q     <= an_d;
         dval_q   <= dval_d;
         fdone_q  <= fdone_d;
         busy_q   <= busy_d;
         rdy_q    <= rdy_d;
      end
   end

   assign AN_EN         = an_q;
   assign digit_val     = dval_q;
   assign frame_done    = fdone_q;
   assign busy          = busy_q;
   assign msg.msg_ready = rdy_q;

endmodule
